// File: rtl/btn_svc_pkg.sv
// Shared definitions for the button interrupt servicer.
//   ADDR_*           PIO word addresses (data, irq mask, edge capture)
//   MASK_ARM         value written to the irq mask at start-up
//   btn_svc_state_t  servicer FSM states
//   max_u            helper used to size the shared timer
package btn_svc_pkg;

  localparam logic [1:0]  ADDR_DATA = 2'd0;
  localparam logic [1:0]  ADDR_MASK = 2'd2;
  localparam logic [1:0]  ADDR_EDGE = 2'd3;
  localparam logic [31:0] MASK_ARM  = 32'h1;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    RD_EDGE,
    WT_EDGE,
    WR_CLR,
    RD_DATA,
    WT_DATA,
    REPORT,
    HOLD
  } btn_svc_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_irq_servicer_if.sv
// Bus bundle between the servicer, the button PIO slave and the event consumer.
//   avm_*     Avalon-MM command/response signals (servicer is the initiator)
//   event_*   valid/ready press-event stream (servicer is the source)
// Modports: master = servicer side, slave = PIO/consumer side.
interface button_irq_servicer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata;
  logic             avm_waitrequest;
  logic             event_valid;
  logic             event_ready;
  logic             event_level;
  logic [CNT_W-1:0] event_count;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, avm_waitrequest,
    output event_valid, event_level, event_count,
    input  event_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, avm_waitrequest,
    input  event_valid, event_level, event_count,
    output event_ready
  );
endinterface

// File: rtl/btn_svc_timer.sv
// Loadable down-counter shared by the read-latency wait and the hold-off window.
//   clk, reset_n  clock, async active-low reset
//   i_load        load i_load_val (has priority over i_dec)
//   i_load_val    value to load
//   i_dec         decrement by one, saturating at zero
//   o_zero        counter is zero
module btn_svc_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/button_irq_servicer.sv
// Avalon-MM initiator that services an edge-capture PIO port: arms the irq mask at start-up,
// then on each irq reads and clears the edge-capture register, samples the pin and offers one
// press event on a valid/ready stream.
//   clk, reset_n  clock, async active-low reset
//   i_enable      1 = service interrupts, 0 = stay idle once the mask is armed
//   i_irq_in      interrupt from the PIO port
//   o_busy        high whenever the FSM is not idle
//   bus           avm_* initiator port and event_* source port
// Optional feature: define BTN_HOLDOFF_EN to add a HOLDOFF_CYCLES ignore window after each event.
module button_irq_servicer
  import btn_svc_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned HOLDOFF_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_enable,
  input  logic                  i_irq_in,
  output logic                  o_busy,
  button_irq_servicer_if.master bus
);

  localparam int unsigned TMR_W = $clog2(max_u(READ_LATENCY, HOLDOFF_CYCLES) + 1);
  // The wait state itself spans one cycle, so load latency-1.
  localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(READ_LATENCY - 1);
`ifdef BTN_HOLDOFF_EN
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);
`endif

  btn_svc_state_t   r_state, w_state_nxt;
  logic             r_cs, w_cs_nxt;
  logic             r_write_n, w_write_n_nxt;
  logic [1:0]       r_addr, w_addr_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic             r_level, w_level_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_busy;

  logic             w_accept;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  logic             w_unused_rdata;

  assign w_accept       = r_cs & ~bus.avm_waitrequest;
  assign w_unused_rdata = ^bus.avm_readdata[31:1];

  btn_svc_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // Command states raise chipselect one cycle after entry and keep it (with stable address and
  // data) until accepted; chipselect is low in the cycle after accept.
  always_comb begin
    w_state_nxt   = r_state;
    w_cs_nxt      = 1'b0;
    w_write_n_nxt = 1'b1;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_level_nxt   = r_level;
    w_count_nxt   = r_count;
    w_tmr_load    = 1'b0;
    w_tmr_val     = LAT_LOAD;
    w_tmr_dec     = 1'b0;

    unique case (r_state)
      INIT: begin
        if (w_accept) begin
          w_state_nxt = IDLE;
        end else begin
          w_cs_nxt      = 1'b1;
          w_write_n_nxt = 1'b0;
          w_addr_nxt    = ADDR_MASK;
          w_wdata_nxt   = MASK_ARM;
        end
      end
      IDLE: begin
        if (i_irq_in && i_enable) w_state_nxt = RD_EDGE;
      end
      RD_EDGE: begin
        if (w_accept) begin
          w_state_nxt = WT_EDGE;
          w_tmr_load  = 1'b1;
        end else begin
          w_cs_nxt   = 1'b1;
          w_addr_nxt = ADDR_EDGE;
        end
      end
      WT_EDGE: begin
        if (w_tmr_zero) begin
          // Edge register clear means the irq was spurious: no write, no event.
          w_state_nxt = bus.avm_readdata[0] ? WR_CLR : IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      WR_CLR: begin
        if (w_accept) begin
          w_state_nxt = RD_DATA;
        end else begin
          w_cs_nxt      = 1'b1;
          w_write_n_nxt = 1'b0;
          w_addr_nxt    = ADDR_EDGE;
          w_wdata_nxt   = 32'h0;
        end
      end
      RD_DATA: begin
        if (w_accept) begin
          w_state_nxt = WT_DATA;
          w_tmr_load  = 1'b1;
        end else begin
          w_cs_nxt   = 1'b1;
          w_addr_nxt = ADDR_DATA;
        end
      end
      WT_DATA: begin
        if (w_tmr_zero) begin
          w_level_nxt = bus.avm_readdata[0];
          w_count_nxt = r_count + 1'b1;
          w_state_nxt = REPORT;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      REPORT: begin
        if (bus.event_ready) begin
`ifdef BTN_HOLDOFF_EN
          w_state_nxt = HOLD;
          w_tmr_load  = 1'b1;
          w_tmr_val   = HOLD_LOAD;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      HOLD: begin
`ifdef BTN_HOLDOFF_EN
        // irq is deliberately not looked at here; the port keeps latching edges.
        if (w_tmr_zero) begin
          w_state_nxt = IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= INIT;
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      r_addr    <= 2'd0;
      r_wdata   <= 32'h0;
      r_level   <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cs      <= w_cs_nxt;
      r_write_n <= w_write_n_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_level   <= w_level_nxt;
      r_count   <= w_count_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign bus.avm_chipselect = r_cs;
  assign bus.avm_write_n    = r_write_n;
  assign bus.avm_address    = r_addr;
  assign bus.avm_writedata  = r_wdata;
  assign bus.event_valid    = (r_state == REPORT);
  assign bus.event_level    = r_level;
  assign bus.event_count    = r_count;
  assign o_busy             = r_busy;

endmodule

// File: tb/tb_button_irq_servicer.sv
// Self-checking bench for button_irq_servicer with a behavioural edge-capture PIO slave
// (configurable read latency, optional write stall) and an event scoreboard.
// Build with BTN_HOLDOFF_EN defined to also exercise the hold-off window (HOLDOFF_CYCLES=8).
module tb_button_irq_servicer;

  localparam int unsigned RL = 2;
  localparam int unsigned CW = 2;
  localparam int unsigned HC = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic irq_in;
  logic busy;

  button_irq_servicer_if #(.CNT_W(CW)) bus ();

  button_irq_servicer #(
    .READ_LATENCY   (RL),
    .CNT_W          (CW),
    .HOLDOFF_CYCLES (HC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_enable (enable),
    .i_irq_in (irq_in),
    .o_busy   (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // ---------------- PIO slave model ----------------
  logic        ready, press_set, pin, spur, stall_en, stall_arm;
  logic [31:0] mdl_mask;
  logic        mdl_edge;
  logic [2:0]  stall_left;
  logic        lat_v [RL];
  logic [31:0] lat_d [RL];
  logic [31:0] rd_val;
  logic        w_wait, w_acc;

  assign w_wait = stall_en & bus.avm_chipselect & ~bus.avm_write_n &
                  (bus.avm_address == 2'd3) & (stall_left != 3'd0);
  assign w_acc  = bus.avm_chipselect & ~w_wait;
  assign bus.avm_waitrequest = w_wait;
  assign bus.event_ready     = ready;
  assign irq_in = (mdl_edge & mdl_mask[0]) | spur;
  // Outside the valid cycle readdata carries the complement, so a mistimed sample is visible.
  assign bus.avm_readdata = lat_v[RL-1] ? lat_d[RL-1] : ~lat_d[RL-1];

  always_comb begin
    rd_val = 32'h0;
    case (bus.avm_address)
      2'd0:    rd_val = {31'h0, pin};
      2'd2:    rd_val = mdl_mask;
      2'd3:    rd_val = {31'h0, mdl_edge};
      default: rd_val = 32'h0;
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_mask   <= 32'h0;
      mdl_edge   <= 1'b0;
      stall_left <= 3'd0;
      for (int i = 0; i < RL; i++) begin
        lat_v[i] <= 1'b0;
        lat_d[i] <= 32'h0;
      end
    end else begin
      if (w_acc && bus.avm_write_n) begin
        lat_v[0] <= 1'b1;
        lat_d[0] <= rd_val;
      end else begin
        lat_v[0] <= 1'b0;
      end
      for (int i = 1; i < RL; i++) begin
        lat_v[i] <= lat_v[i-1];
        lat_d[i] <= lat_d[i-1];
      end
      if (w_acc && !bus.avm_write_n && bus.avm_address == 2'd2) mdl_mask <= bus.avm_writedata;
      if (press_set) mdl_edge <= 1'b1;
      else if (w_acc && !bus.avm_write_n && bus.avm_address == 2'd3) mdl_edge <= 1'b0;
      if (stall_arm) stall_left <= 3'd4;
      else if (w_wait) stall_left <= stall_left - 3'd1;
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    logic          lvl;
    logic [CW-1:0] cnt;
  } ev_t;
  typedef struct {
    logic        wn;
    logic [1:0]  a;
    logic [31:0] d;
  } cmd_t;
  typedef struct {
    logic edge_v;
    logic pin_v;
    logic en_v;
  } vec_t;

  ev_t  sb_q [$];
  cmd_t cmd_q [$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_vcyc = 0;
  int   n_wait = 0;
  int   bad_w = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset_n) begin
      if (w_acc) cmd_q.push_back('{bus.avm_write_n, bus.avm_address, bus.avm_writedata});
      if (bus.event_valid) n_vcyc++;
      if (w_wait) begin
        n_wait++;
        if (bus.avm_writedata != 32'h0) bad_w++;
      end
      if (bus.event_valid && bus.event_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL evt_unexpected: got level=%0d count=%0d, want no event",
                   bus.event_level, bus.event_count);
        end else begin
          e = sb_q.pop_front();
          chk("evt_level", 64'(bus.event_level), 64'(e.lvl));
          chk("evt_count", 64'(bus.event_count), 64'(e.cnt));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic lvl);
    step();
    pin       = lvl;
    press_set = 1'b1;
    exp_cnt   = exp_cnt + 1'b1;
    sb_q.push_back('{lvl, exp_cnt});
    step();
    press_set = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0d, want 0/0", nm, sb_q.size(), busy);
    end
  endtask

  task automatic chk_cmd(input string nm, input logic wn, input logic [1:0] a,
                         input logic [31:0] d);
    cmd_t c;
    if (cmd_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no command, want wn=%0d addr=%0d", nm, wn, a);
    end else begin
      c = cmd_q.pop_front();
      chk(nm, {c.wn, c.a, (c.wn ? 32'h0 : c.d)}, {wn, a, (wn ? 32'h0 : d)});
    end
  endtask

  task automatic chk_service(input string nm);
    chk({nm, "_ncmd"}, 64'(cmd_q.size()), 64'd3);
    chk_cmd({nm, "_rd3"}, 1'b1, 2'd3, 32'h0);
    chk_cmd({nm, "_wr3"}, 1'b0, 2'd3, 32'h0);
    chk_cmd({nm, "_rd0"}, 1'b1, 2'd0, 32'h0);
    cmd_q.delete();
  endtask

  task automatic chk_init_write(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.avm_chipselect) seen = 1'b1;
    end
    chk({nm, "_cs"}, 64'(seen), 64'd1);
    chk({nm, "_cmd"}, {bus.avm_write_n, bus.avm_address, bus.avm_writedata}, {1'b0, 2'd2, 32'h1});
    @(negedge clk);
    chk({nm, "_cs_drop"}, 64'(bus.avm_chipselect), 64'd0);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int n;
    int bad;
    int bad_bus;
    bit ok;
    logic          lvl0;
    logic [CW-1:0] cnt0;

    // edge, pin, enable
    vecs[0] = '{1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1};  // spurious irq
    vecs[3] = '{1'b1, 1'b1, 1'b0};  // pending while disabled
    vecs[4] = '{1'b1, 1'b0, 1'b1};  // 4th event: count wraps to 0
    vecs[5] = '{1'b1, 1'b1, 1'b1};  // 5th event: count 1

    reset_n = 1'b0; enable = 1'b1; ready = 1'b1; press_set = 1'b0; pin = 1'b0;
    spur = 1'b0; stall_en = 1'b0; stall_arm = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata,
                        bus.event_valid, bus.event_level, busy},
                       {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0});
    chk("rst_count", 64'(bus.event_count), 64'd0);
    step();
    reset_n = 1'b1;
    chk_init_write("init");
    cmd_q.delete();

    for (int v = 0; v < 6; v++) begin
      enable = vecs[v].en_v;
      n_vcyc = 0;
      if (!vecs[v].edge_v) begin
        step();
        spur = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
          @(negedge clk);
          if (busy) ok = 1'b1;
        end
        step();
        spur = 1'b0;
        n = 1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (!busy) break;
          n++;
        end
        chk($sformatf("v%0d_spur_busy", v), 64'(n), 64'(RL + 2));
        chk($sformatf("v%0d_spur_ncmd", v), 64'(cmd_q.size()), 64'd1);
        chk_cmd($sformatf("v%0d_spur_rd3", v), 1'b1, 2'd3, 32'h0);
        chk($sformatf("v%0d_spur_count", v), 64'(bus.event_count), 64'(exp_cnt));
        chk($sformatf("v%0d_spur_noevt", v), 64'(n_vcyc), 64'd0);
        cmd_q.delete();
      end else begin
        press(vecs[v].pin_v);
        if (!vecs[v].en_v) begin
          n = 0;
          repeat (10) begin
            @(negedge clk);
            if (busy) n++;
          end
          chk($sformatf("v%0d_dis_busy", v), 64'(n), 64'd0);
          chk($sformatf("v%0d_dis_ncmd", v), 64'(cmd_q.size()), 64'd0);
          step();
          enable = 1'b1;
        end
        wait_done($sformatf("v%0d", v));
        chk_service($sformatf("v%0d", v));
        chk($sformatf("v%0d_valid_cycles", v), 64'(n_vcyc), 64'd1);
      end
    end

    // Consumer stalls in REPORT; an edge arriving after the clear is serviced afterwards.
    step();
    ready = 1'b0;
    press(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.event_valid) ok = 1'b1;
    end
    chk("stall_valid", 64'(ok), 64'd1);
    lvl0 = bus.event_level;
    cnt0 = bus.event_count;
    press(1'b0);
    bad = 0;
    bad_bus = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.event_valid || bus.event_level !== lvl0 || bus.event_count !== cnt0) bad++;
      if (bus.avm_chipselect) bad_bus++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    chk("stall_no_bus", 64'(bad_bus), 64'd0);
    step();
    ready = 1'b1;
    wait_done("stall");
    chk("stall_ncmd", 64'(cmd_q.size()), 64'd6);
    cmd_q.delete();

    // Reset during WT_DATA.
    press(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (w_acc && bus.avm_write_n && bus.avm_address == 2'd0) ok = 1'b1;
    end
    chk("rst_mid_reach", 64'(ok), 64'd1);
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address,
                            bus.avm_writedata, bus.event_valid, bus.event_level, busy},
                           {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0});
    chk("rst_mid_count", 64'(bus.event_count), 64'd0);
    sb_q.delete();
    cmd_q.delete();
    exp_cnt = '0;
    repeat (2) step();
    reset_n = 1'b1;
    chk_init_write("reinit");
    chk("reinit_count", 64'(bus.event_count), 64'd0);
    cmd_q.delete();

    // waitrequest stalls the edge-clear write for 4 cycles.
    n_wait = 0;
    bad_w = 0;
    step();
    stall_en  = 1'b1;
    stall_arm = 1'b1;
    step();
    stall_arm = 1'b0;
    press(1'b0);
    wait_done("wreq");
    chk("wreq_cycles", 64'(n_wait), 64'd4);
    chk("wreq_data_stable", 64'(bad_w), 64'd0);
    chk_service("wreq");
    stall_en = 1'b0;

`ifdef BTN_HOLDOFF_EN
    // Second irq three cycles after the handshake waits out the hold window.
    press(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.event_valid && bus.event_ready) ok = 1'b1;
    end
    chk("hold_hs", 64'(ok), 64'd1);
    step();
    press(1'b0);
    n = 2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.avm_chipselect) break;
    end
    chk("hold_delay", 64'(n), 64'(HC + 3));
    wait_done("hold");
    cmd_q.delete();
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400us, want finish");
    $fatal(1);
  end

endmodule
